// File: rtl/accum_16bit_seq.sv
// ---------------------------------------------------------------------------
// accum_16bit_seq
//
// Sequential accumulator. An accepted start fixes the run length `count`.
// The block then sums that many operands, taken over a valid/ready
// handshake, into a WIDTH-bit accumulator. A run with count == 0 completes
// at once with a zero sum.
//
// Each accepted operand updates these outputs:
//   acc        : sum modulo 2^WIDTH.
//   last_carry : carry out of the most recent addition.
//   carry_cnt  : number of additions in the run that produced a carry.
// The three results hold after the run ends, until the next accepted start.
//
// Ports
//   clk        in   clock; all state changes on its rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a run (acted on only in IDLE)
//   count      in   number of operands, sampled with an accepted start
//   din        in   operand data
//   din_valid  in   din holds a valid operand
//   din_ready  out  operand accepted this cycle if din_valid (ACC only)
//   acc        out  running / final sum
//   last_carry out  carry of the most recent addition
//   carry_cnt  out  additions in this run that carried
//   busy       out  run in progress (ACC only)
//   done       out  one-cycle completion pulse (DONE only)
// ---------------------------------------------------------------------------
module accum_16bit_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] acc,
  output logic             last_carry,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic             r_last_carry;
  logic [CNT_W-1:0] r_carry_cnt;
  logic [CNT_W-1:0] r_remaining;

  logic             w_start_ok;
  logic             w_handshake;
  logic [WIDTH:0]   w_sum;

  // start matters only in IDLE; din matters only while ready in ACC.
  assign w_start_ok  = (r_state == S_IDLE) && start;
  assign w_handshake = (r_state == S_ACC) && din_valid;

  // The sum is one bit wider than the operands. Its MSB is the carry out.
  assign w_sum = {1'b0, r_acc} + {1'b0, din};

  // NOTE: the next state gets a default before the case statement. That way
  // every path assigns it, and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (count != '0) ? S_ACC : S_DONE;
        end
      end
      S_ACC: begin
        if (w_handshake && (r_remaining == CNT_W'(1))) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments. Every read in this block
  // then sees the pre-edge value, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset is tested first. It overrides start and a same-cycle handshake.
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_last_carry <= 1'b0;
      r_carry_cnt  <= '0;
      r_remaining  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_acc        <= '0;
        r_last_carry <= 1'b0;
        r_carry_cnt  <= '0;
        r_remaining  <= count;
      end else if (w_handshake) begin
        r_acc        <= w_sum[WIDTH-1:0];
        r_last_carry <= w_sum[WIDTH];
        // Carries cannot outnumber operands, so this never wraps.
        if (w_sum[WIDTH]) begin
          r_carry_cnt <= r_carry_cnt + CNT_W'(1);
        end
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  assign din_ready  = (r_state == S_ACC);
  assign busy       = (r_state == S_ACC);
  assign done       = (r_state == S_DONE);
  assign acc        = r_acc;
  assign last_carry = r_last_carry;
  assign carry_cnt  = r_carry_cnt;

endmodule

// File: tb/tb_accum_16bit_seq.sv
// ---------------------------------------------------------------------------
// tb_accum_16bit_seq
//
// Scenario tasks drive accum_16bit_seq. They compare its outputs with a sum
// computed here in plain integer arithmetic. Inputs change 1 time unit after
// the rising edge, and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_accum_16bit_seq;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] acc;
  logic             last_carry;
  logic [CNT_W-1:0] carry_cnt;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  // Operands of the run about to be driven.
  logic [WIDTH-1:0] q_ops[$];

  // Reference results.
  int m_acc;
  bit m_lc;
  int m_cc;
  int last_busy;

  accum_16bit_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .count      (count),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .acc        (acc),
    .last_carry (last_carry),
    .carry_cnt  (carry_cnt),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer sum. A carry is any result above 2^WIDTH-1.
  task automatic model_add(input logic [WIDTH-1:0] v);
    int s;
    s     = m_acc + int'(v);
    m_lc  = (s > 65535);
    if (m_lc) m_cc++;
    m_acc = s % 65536;
  endtask

  // Runs q_ops through the DUT. Up to gap_min..gap_max idle cycles precede
  // each operand. The task checks every step against the reference.
  task automatic do_run(input int gap_min, input int gap_max);
    int n;
    int g;
    int gaps;
    int busy_seen;
    logic [WIDTH-1:0] e_acc;
    logic [CNT_W-1:0] e_cc;
    n         = q_ops.size();
    gaps      = 0;
    busy_seen = 0;
    m_acc = 0; m_lc = 1'b0; m_cc = 0;

    start     = 1'b1;
    count     = CNT_W'(n);
    din_valid = 1'b0;
    step();
    start = 1'b0;
    count = CNT_W'($urandom);

    if (n == 0) begin
      total++;
      if ({done, din_ready, busy} !== 3'b100) begin
        bad++;
        $display("FAIL zero_done: done/ready/busy=%b want 100", {done, din_ready, busy});
      end
      total++;
      if ({acc, last_carry, carry_cnt} !== '0) begin
        bad++;
        $display("FAIL zero_clear: acc=%h lc=%b cc=%0d want all 0", acc, last_carry, carry_cnt);
      end
      step();
      total++;
      if ({done, din_ready, busy} !== 3'b000) begin
        bad++;
        $display("FAIL zero_after: done/ready/busy=%b want 000", {done, din_ready, busy});
      end
      last_busy = 0;
      return;
    end

    if (busy) busy_seen++;
    total++;
    if (din_ready !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL run_enter: ready=%b done=%b want 1 0", din_ready, done);
    end
    total++;
    if ({acc, last_carry, carry_cnt} !== '0) begin
      bad++;
      $display("FAIL run_clear: acc=%h lc=%b cc=%0d want all 0", acc, last_carry, carry_cnt);
    end

    for (int i = 0; i < n; i++) begin
      g = $urandom_range(gap_max, gap_min);
      repeat (g) begin
        din_valid = 1'b0;
        din       = WIDTH'($urandom);
        step();
        gaps++;
        if (busy) busy_seen++;
        e_acc = m_acc[WIDTH-1:0];
        total++;
        if (acc !== e_acc || din_ready !== 1'b1) begin
          bad++;
          $display("FAIL gap_hold: acc=%h ready=%b want %h 1", acc, din_ready, e_acc);
        end
      end
      din_valid = 1'b1;
      din       = q_ops[i];
      step();
      model_add(q_ops[i]);
      din_valid = 1'b0;
      din       = WIDTH'($urandom);
      if (busy) busy_seen++;
      e_acc = m_acc[WIDTH-1:0];
      e_cc  = m_cc[CNT_W-1:0];
      total++;
      if ({acc, last_carry, carry_cnt} !== {e_acc, m_lc, e_cc}) begin
        bad++;
        $display("FAIL hs_result[%0d]: acc=%h lc=%b cc=%0d want %h %b %0d",
                 i, acc, last_carry, carry_cnt, e_acc, m_lc, e_cc);
      end
      total++;
      if (i < n - 1) begin
        if ({done, busy} !== 2'b01) begin
          bad++;
          $display("FAIL hs_midrun[%0d]: done/busy=%b want 01", i, {done, busy});
        end
      end else begin
        if ({done, busy, din_ready} !== 3'b100) begin
          bad++;
          $display("FAIL hs_done: done/busy/ready=%b want 100", {done, busy, din_ready});
        end
      end
    end

    last_busy = busy_seen;
    total++;
    if (busy_seen != n + gaps) begin
      bad++;
      $display("FAIL busy_len: busy cycles=%0d want %0d", busy_seen, n + gaps);
    end

    step();
    total++;
    if ({done, busy, din_ready} !== 3'b000 || acc !== e_acc || carry_cnt !== e_cc) begin
      bad++;
      $display("FAIL idle_hold: done/busy/ready=%b acc=%h cc=%0d want 000 %h %0d",
               {done, busy, din_ready}, acc, carry_cnt, e_acc, e_cc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; count = 4'd3; din_valid = 1'b1; din = 16'hFFFF;
    step();
    step();
    total++;
    if ({acc, last_carry, carry_cnt, done, busy, din_ready} !== '0) begin
      bad++;
      $display("FAIL reset_state: acc=%h lc=%b cc=%0d done=%b busy=%b ready=%b want all 0",
               acc, last_carry, carry_cnt, done, busy, din_ready);
    end
    rst = 1'b0; start = 1'b0; din_valid = 1'b0;
    step();
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle: busy/done=%b want 00", {busy, done});
    end
  endtask

  task automatic test_two_operand();
    q_ops = '{16'h158A, 16'h7095};
    do_run(0, 0);
    total++;
    if ({acc, last_carry, carry_cnt} !== {16'h861F, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL two_op: acc=%h lc=%b cc=%0d want 861f 0 0", acc, last_carry, carry_cnt);
    end
  endtask

  task automatic test_carry();
    q_ops = '{16'h52AF, 16'hB903};
    do_run(0, 0);
    total++;
    if ({acc, last_carry, carry_cnt} !== {16'h0BB2, 1'b1, 4'd1}) begin
      bad++;
      $display("FAIL carry: acc=%h lc=%b cc=%0d want 0bb2 1 1", acc, last_carry, carry_cnt);
    end
  endtask

  task automatic test_back_pressure();
    q_ops = '{16'h158A, 16'h7095, 16'h9A4E};
    do_run(2, 2);
    total++;
    if (acc !== 16'h206D || carry_cnt !== 4'd1) begin
      bad++;
      $display("FAIL backpressure: acc=%h cc=%0d want 206d 1", acc, carry_cnt);
    end
  endtask

  task automatic test_max_count();
    q_ops = {};
    repeat (15) q_ops.push_back(16'hFFFF);
    do_run(0, 0);
    total++;
    if (acc !== 16'hFFF1 || carry_cnt !== 4'd14 || last_busy != 15) begin
      bad++;
      $display("FAIL max_count: acc=%h cc=%0d busy=%0d want fff1 14 15", acc, carry_cnt, last_busy);
    end
  endtask

  task automatic test_count_zero();
    q_ops = {};
    do_run(0, 0);
  endtask

  task automatic test_start_during_acc();
    logic [WIDTH-1:0] a, b, c, e_acc;
    a = WIDTH'($urandom); b = WIDTH'($urandom); c = WIDTH'($urandom);
    m_acc = 0; m_lc = 1'b0; m_cc = 0;
    start = 1'b1; count = 4'd3; step(); start = 1'b0;
    din_valid = 1'b1; din = a; step(); model_add(a);
    din_valid = 1'b0; start = 1'b1; count = 4'd1; step(); start = 1'b0;
    total++;
    if ({busy, din_ready, done} !== 3'b110) begin
      bad++;
      $display("FAIL acc_start_state: busy/ready/done=%b want 110", {busy, din_ready, done});
    end
    din_valid = 1'b1; din = b; step(); model_add(b); din_valid = 1'b0;
    total++;
    if ({busy, done} !== 2'b10) begin
      bad++;
      $display("FAIL acc_start_remaining: busy/done=%b want 10", {busy, done});
    end
    din_valid = 1'b1; din = c; step(); model_add(c); din_valid = 1'b0;
    e_acc = m_acc[WIDTH-1:0];
    total++;
    if (done !== 1'b1 || acc !== e_acc) begin
      bad++;
      $display("FAIL acc_start_final: done=%b acc=%h want 1 %h", done, acc, e_acc);
    end
    // start during DONE is ignored: the block falls back to IDLE.
    start = 1'b1; count = 4'd2; step(); start = 1'b0;
    total++;
    if ({busy, done, din_ready} !== 3'b000 || acc !== e_acc) begin
      bad++;
      $display("FAIL done_start: busy/done/ready=%b acc=%h want 000 %h",
               {busy, done, din_ready}, acc, e_acc);
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; count = 4'd3; step(); start = 1'b0;
    din_valid = 1'b1; din = 16'hFFFF; step();
    rst = 1'b1; din = 16'h0003; step();
    rst = 1'b0; din_valid = 1'b0;
    total++;
    if ({acc, last_carry, carry_cnt, done, busy, din_ready} !== '0) begin
      bad++;
      $display("FAIL mid_reset: acc=%h lc=%b cc=%0d done=%b busy=%b ready=%b want all 0",
               acc, last_carry, carry_cnt, done, busy, din_ready);
    end
    q_ops = '{16'h0005};
    do_run(0, 0);
    total++;
    if (acc !== 16'h0005 || carry_cnt !== 4'd0) begin
      bad++;
      $display("FAIL post_reset_run: acc=%h cc=%0d want 0005 0", acc, carry_cnt);
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(15, 0);
      q_ops = {};
      for (int k = 0; k < n; k++) q_ops.push_back(WIDTH'($urandom));
      do_run(0, 3);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; din = '0; din_valid = 1'b0;
    test_reset();
    test_two_operand();
    test_carry();
    test_back_pressure();
    test_max_count();
    test_count_zero();
    test_start_during_acc();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
